// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: FSM states, mux/ALU encodings and instruction field constants for mc_control.
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    fetch, decode, r_exec, r_wb, addi_exec, addi_wb, mem_addr,
    mem_read, load_wb, mem_write, branch, jump, exc
  } state_t;
  localparam logic [2:0] srcb_reg = 3'b000, srcb_ext = 3'b001, srcb_four = 3'b010, srcb_sh = 3'b100;
  localparam logic [2:0] alu_add = 3'b000, alu_sub = 3'b001, alu_and = 3'b010, alu_or = 3'b011, alu_slt = 3'b100;
  localparam logic [1:0] pc_alu = 2'b00, pc_out = 2'b01, pc_jmp = 2'b10, pc_exc = 2'b11;
  localparam logic [1:0] c_none = 2'b00, c_inv = 2'b01, c_ovf = 2'b10;
  localparam logic [5:0] op_r = 6'h00, op_j = 6'h02, op_beq = 6'h04, op_bne = 6'h05;
  localparam logic [5:0] op_addi = 6'h08, op_lw = 6'h23, op_sw = 6'h2b;
  localparam logic [5:0] f_add = 6'h20, f_sub = 6'h22, f_and = 6'h24, f_or = 6'h25, f_slt = 6'h2a;
  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {f_add, f_sub, f_and, f_or, f_slt};
  endfunction
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    return f == f_sub ? alu_sub : f == f_and ? alu_and : f == f_or ? alu_or : f == f_slt ? alu_slt : alu_add;
  endfunction
endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: instruction/flag inputs and datapath control strobes of the multicycle controller.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic overflow;
  logic alu_src_a;
  logic [2:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic pc_write;
  logic ir_write;
  logic iord;
  logic mem_rd;
  logic mem_wr;
  logic reg_write;
  logic reg_dst;
  logic mem_to_reg;
  logic epc_write;
  logic [1:0] cause;
  modport master (
    input opcode, funct, zero, overflow,
    output alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, iord, mem_rd, mem_wr,
    reg_write, reg_dst, mem_to_reg, epc_write, cause
  );
  modport slave (
    output opcode, funct, zero, overflow,
    input alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, iord, mem_rd, mem_wr,
    reg_write, reg_dst, mem_to_reg, epc_write, cause
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: Moore decode of controller state to datapath strobes; MC_CTRL_EXC_EN enables the EXC outputs.
module mc_ctrl_outdec import mc_ctrl_pkg::*; (
  input  state_t     st,
  input  logic       last,
  input  logic       reset,
  input  logic       zero,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [1:0] exc_cause,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic [1:0] cause
);
  logic on, taken, exc_on;
  always_comb begin
    on = !reset;
`ifdef MC_CTRL_EXC_EN
    exc_on = on && st == exc;
`else
    exc_on = 1'b0;
`endif
    taken = opcode == op_beq ? zero : opcode == op_bne ? !zero : 1'b0;
    alu_src_a = on && st inside {r_exec, addi_exec, mem_addr, branch};
    alu_src_b = !on ? srcb_reg : st == fetch ? srcb_four : st == decode ? srcb_sh :
                st inside {addi_exec, mem_addr} ? srcb_ext : srcb_reg;
    alu_op = !on ? alu_add : st == branch ? alu_sub : st == r_exec ? funct_alu(funct) : alu_add;
    pc_src = !on ? pc_alu : st == branch ? pc_out : st == jump ? pc_jmp : exc_on ? pc_exc : pc_alu;
    pc_write = on && ((st == fetch && last) || (st == branch && taken) || st == jump || exc_on);
    ir_write = on && st == fetch && last;
    mem_rd = on && st inside {fetch, mem_read};
    iord = on && st inside {mem_read, mem_write};
    mem_wr = on && st == mem_write;
    reg_write = on && st inside {r_wb, addi_wb, load_wb};
    reg_dst = on && st == r_wb;
    mem_to_reg = on && st == load_wb;
    epc_write = exc_on;
    cause = exc_on ? exc_cause : c_none;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle CPU control FSM (FETCH..EXC) with MEM_LAT-cycle memory waits.
// Define MC_CTRL_EXC_EN to trap invalid opcode/funct and add/sub/addi overflow into EXC.
module mc_control import mc_ctrl_pkg::*; #(
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  mc_control_if.master bus
);
`ifdef MC_CTRL_EXC_EN
  localparam state_t bad_st = exc;
  localparam bit ov_en = 1'b1;
`else
  localparam state_t bad_st = fetch;
  localparam bit ov_en = 1'b0;
`endif
  state_t st, nxt;
  logic [2:0] cnt;
  logic [1:0] exc_q, exc_d;
  logic last, arith;
  assign last = cnt == 3'(MEM_LAT - 1);
  assign arith = bus.funct inside {f_add, f_sub};
  always_comb begin
    nxt = st;
    exc_d = exc_q;
    case (st)
      fetch:     nxt = last ? decode : fetch;
      decode: begin
        nxt = bus.opcode == op_r ? r_exec : bus.opcode == op_addi ? addi_exec :
              bus.opcode inside {op_lw, op_sw} ? mem_addr :
              bus.opcode inside {op_beq, op_bne} ? branch : bus.opcode == op_j ? jump : bad_st;
        exc_d = c_inv;
      end
      r_exec: begin
        nxt = !funct_ok(bus.funct) ? bad_st : ov_en && bus.overflow && arith ? exc : r_wb;
        exc_d = funct_ok(bus.funct) ? c_ovf : c_inv;
      end
      addi_exec: begin
        nxt = ov_en && bus.overflow ? exc : addi_wb;
        exc_d = c_ovf;
      end
      mem_addr:  nxt = bus.opcode == op_lw ? mem_read : mem_write;
      mem_read:  nxt = last ? load_wb : mem_read;
      default:   nxt = fetch;
    endcase
  end
  // the wait counter restarts on every state entry, so only FETCH/MEM_READ ever count past 0
  always_ff @(posedge clk)
    if (reset) begin
      st <= fetch;
      cnt <= '0;
      exc_q <= c_none;
    end else begin
      st <= nxt;
      cnt <= nxt == st ? cnt + 3'd1 : 3'd0;
      exc_q <= exc_d;
    end
  mc_ctrl_outdec u_outdec (
    .st(st), .last(last), .reset(reset), .zero(bus.zero), .opcode(bus.opcode), .funct(bus.funct),
    .exc_cause(exc_q), .alu_src_a(bus.alu_src_a), .alu_src_b(bus.alu_src_b), .alu_op(bus.alu_op),
    .pc_src(bus.pc_src), .pc_write(bus.pc_write), .ir_write(bus.ir_write), .iord(bus.iord),
    .mem_rd(bus.mem_rd), .mem_wr(bus.mem_wr), .reg_write(bus.reg_write), .reg_dst(bus.reg_dst),
    .mem_to_reg(bus.mem_to_reg), .epc_write(bus.epc_write), .cause(bus.cause)
  );
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed checks of mc_control with MEM_LAT=1 (d1) and MEM_LAT=3 (d3).
module tb_mc_control;
  // vector order: alu_src_a, alu_src_b, alu_op, pc_src, pc_write, ir_write, iord, mem_rd, mem_wr,
  // reg_write, reg_dst, mem_to_reg, epc_write, cause
  localparam logic [19:0] v_f1  = 20'b0_010_000_00_1_1_0_1_0_0_0_0_0_00;
  localparam logic [19:0] v_fw  = 20'b0_010_000_00_0_0_0_1_0_0_0_0_0_00;
  localparam logic [19:0] v_dec = 20'b0_100_000_00_0_0_0_0_0_0_0_0_0_00;
  localparam logic [19:0] v_rxa = 20'b1_000_000_00_0_0_0_0_0_0_0_0_0_00;
  localparam logic [19:0] v_rwb = 20'b0_000_000_00_0_0_0_0_0_1_1_0_0_00;
  localparam logic [19:0] v_ax  = 20'b1_001_000_00_0_0_0_0_0_0_0_0_0_00;
  localparam logic [19:0] v_awb = 20'b0_000_000_00_0_0_0_0_0_1_0_0_0_00;
  localparam logic [19:0] v_mr  = 20'b0_000_000_00_0_0_1_1_0_0_0_0_0_00;
  localparam logic [19:0] v_lwb = 20'b0_000_000_00_0_0_0_0_0_1_0_1_0_00;
  localparam logic [19:0] v_mw  = 20'b0_000_000_00_0_0_1_0_1_0_0_0_0_00;
  localparam logic [19:0] v_brt = 20'b1_000_001_01_1_0_0_0_0_0_0_0_0_00;
  localparam logic [19:0] v_brn = 20'b1_000_001_01_0_0_0_0_0_0_0_0_0_00;
  localparam logic [19:0] v_jmp = 20'b0_000_000_10_1_0_0_0_0_0_0_0_0_00;
`ifdef MC_CTRL_EXC_EN
  localparam logic [19:0] v_exi = 20'b0_000_000_11_1_0_0_0_0_0_0_0_1_01;
  localparam logic [19:0] v_exo = 20'b0_000_000_11_1_0_0_0_0_0_0_0_1_10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [19:0] o1, o3;
  mc_control_if b1();
  mc_control_if b3();
  mc_control #(.MEM_LAT(1)) d1 (.clk(clk), .reset(reset), .bus(b1.master));
  mc_control #(.MEM_LAT(3)) d3 (.clk(clk), .reset(reset), .bus(b3.master));
  always #5 clk = ~clk;
  always_comb o1 = {b1.alu_src_a, b1.alu_src_b, b1.alu_op, b1.pc_src, b1.pc_write, b1.ir_write, b1.iord,
                    b1.mem_rd, b1.mem_wr, b1.reg_write, b1.reg_dst, b1.mem_to_reg, b1.epc_write, b1.cause};
  always_comb o3 = {b3.alu_src_a, b3.alu_src_b, b3.alu_op, b3.pc_src, b3.pc_write, b3.ir_write, b3.iord,
                    b3.mem_rd, b3.mem_wr, b3.reg_write, b3.reg_dst, b3.mem_to_reg, b3.epc_write, b3.cause};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    b1.opcode = op; b1.funct = fn; b1.zero = z; b1.overflow = ov;
    b3.opcode = op; b3.funct = fn; b3.zero = z; b3.overflow = ov;
  endtask

  // leaves both DUTs in cycle 1 of FETCH
  task automatic do_reset;
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    set_in(6'h23, 6'h20, 1'b1, 1'b1);
    reset = 1'b1;
    step;
    step;
    total++;
    if (o1 !== 20'b0) begin bad++; $display("FAIL reset_out1 got %b exp %b", o1, 20'b0); end
    total++;
    if (o3 !== 20'b0) begin bad++; $display("FAIL reset_out3 got %b exp %b", o3, 20'b0); end
    total++;
    if (d1.st !== mc_ctrl_pkg::fetch) begin bad++; $display("FAIL reset_state got %0d exp %0d", d1.st, mc_ctrl_pkg::fetch); end
  endtask

  task automatic test_add;
    logic [19:0] e [$];
    set_in(6'h00, 6'h20, 1'b0, 1'b0);
    do_reset;
    e = '{v_f1, v_dec, v_rxa, v_rwb, v_f1};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL add cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
  endtask

  task automatic test_r_ops;
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [2:0] op [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [19:0] ex;
    for (int k = 0; k < 5; k++) begin
      set_in(6'h00, fn[k], 1'b0, 1'b0);
      do_reset;
      step;
      step;
      ex = {1'b1, 3'b000, op[k], 13'b0};
      total++;
      if (o1 !== ex) begin bad++; $display("FAIL r_exec funct=%h got %b exp %b", fn[k], o1, ex); end
    end
  endtask

  task automatic test_mem;
    logic [19:0] e [$];
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    do_reset;
    e = '{v_fw, v_fw, v_f1, v_dec, v_ax, v_mr, v_mr, v_mr, v_lwb, v_fw};
    foreach (e[i]) begin
      total++;
      if (o3 !== e[i]) begin bad++; $display("FAIL lw_lat3 cyc%0d got %b exp %b", i + 1, o3, e[i]); end
      step;
    end
    do_reset;
    e = '{v_f1, v_dec, v_ax, v_mr, v_lwb, v_f1};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL lw_lat1 cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
    set_in(6'h2b, 6'h00, 1'b0, 1'b0);
    do_reset;
    e = '{v_f1, v_dec, v_ax, v_mw, v_f1};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL sw cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
  endtask

  task automatic test_addi_jump;
    logic [19:0] e [$];
    set_in(6'h08, 6'h00, 1'b0, 1'b0);
    do_reset;
    e = '{v_f1, v_dec, v_ax, v_awb, v_f1};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL addi cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
    set_in(6'h02, 6'h00, 1'b0, 1'b0);
    do_reset;
    e = '{v_f1, v_dec, v_jmp, v_f1};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL jump cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
  endtask

  task automatic test_branch;
    logic [5:0] op [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
    logic z [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [19:0] ex [4] = '{v_brt, v_brn, v_brn, v_brt};
    for (int k = 0; k < 4; k++) begin
      set_in(op[k], 6'h00, z[k], 1'b0);
      do_reset;
      step;
      step;
      total++;
      if (o1 !== ex[k]) begin bad++; $display("FAIL branch op=%h zero=%b got %b exp %b", op[k], z[k], o1, ex[k]); end
      step;
      total++;
      if (o1 !== v_f1) begin bad++; $display("FAIL branch_ret op=%h got %b exp %b", op[k], o1, v_f1); end
    end
  endtask

  task automatic test_invalid;
    logic [19:0] e [$];
    set_in(6'h3f, 6'h20, 1'b0, 1'b0);
    do_reset;
`ifdef MC_CTRL_EXC_EN
    e = '{v_f1, v_dec, v_exi, v_f1};
`else
    e = '{v_f1, v_dec, v_f1, v_dec};
`endif
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL bad_opcode cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
    set_in(6'h00, 6'h00, 1'b0, 1'b0);
    do_reset;
`ifdef MC_CTRL_EXC_EN
    e = '{v_f1, v_dec, v_rxa, v_exi, v_f1};
`else
    e = '{v_f1, v_dec, v_rxa, v_f1, v_dec};
`endif
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL bad_funct cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
  endtask

  task automatic test_overflow;
    logic [19:0] e [$];
    set_in(6'h00, 6'h22, 1'b0, 1'b1);
    do_reset;
`ifdef MC_CTRL_EXC_EN
    e = '{v_f1, v_dec, {1'b1, 3'b000, 3'b001, 13'b0}, v_exo, v_f1};
`else
    e = '{v_f1, v_dec, {1'b1, 3'b000, 3'b001, 13'b0}, v_rwb, v_f1};
`endif
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL sub_ovf cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
    set_in(6'h08, 6'h00, 1'b0, 1'b1);
    do_reset;
`ifdef MC_CTRL_EXC_EN
    e = '{v_f1, v_dec, v_ax, v_exo, v_f1};
`else
    e = '{v_f1, v_dec, v_ax, v_awb, v_f1};
`endif
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL addi_ovf cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
    set_in(6'h00, 6'h24, 1'b0, 1'b1);
    do_reset;
    e = '{v_f1, v_dec, {1'b1, 3'b000, 3'b010, 13'b0}, v_rwb};
    foreach (e[i]) begin
      total++;
      if (o1 !== e[i]) begin bad++; $display("FAIL and_ovf cyc%0d got %b exp %b", i + 1, o1, e[i]); end
      step;
    end
  endtask

  task automatic test_reset_mid;
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    do_reset;
    repeat (6) step;
    total++;
    if (o3 !== v_mr) begin bad++; $display("FAIL mid_pre got %b exp %b", o3, v_mr); end
    reset = 1'b1;
    #1;
    total++;
    if (o3 !== 20'b0) begin bad++; $display("FAIL mid_out got %b exp %b", o3, 20'b0); end
    step;
    total++;
    if (d3.st !== mc_ctrl_pkg::fetch) begin bad++; $display("FAIL mid_state got %0d exp %0d", d3.st, mc_ctrl_pkg::fetch); end
    total++;
    if (d3.cnt !== 3'd0) begin bad++; $display("FAIL mid_cnt got %0d exp 0", d3.cnt); end
    total++;
    if (o3 !== 20'b0) begin bad++; $display("FAIL mid_hold got %b exp %b", o3, 20'b0); end
    reset = 1'b0;
    #1;
    total++;
    if (o3 !== v_fw) begin bad++; $display("FAIL mid_fetch1 got %b exp %b", o3, v_fw); end
    step;
    step;
    total++;
    if (o3 !== v_f1) begin bad++; $display("FAIL mid_fetch3 got %b exp %b", o3, v_f1); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_r_ops;
    test_mem;
    test_addi_jump;
    test_branch;
    test_invalid;
    test_overflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (legal range 1..7).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  6  IR[31:26], stable from DECODE onward.
REQ-005 SHALL have port funct  in  6  IR[5:0].
REQ-006 SHALL have port zero  in  1  ALU zero flag, same cycle.
REQ-007 SHALL have port overflow  in  1  ALU signed overflow, same cycle.
REQ-008 SHALL have port alu_src_a  out  1  0=PC, 1=reg A.
REQ-009 SHALL have port alu_src_b  out  3  ALU-B mux select: 000 B, 001 ext16_32, 010 const 4, 011 const 1, 100 ext16_32<<2.
REQ-010 SHALL have port alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-011 SHALL have port pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
REQ-012 SHALL have port pc_write  out  1  PC load strobe.
REQ-013 SHALL have port ir_write  out  1  IR load strobe.
REQ-014 SHALL have port iord  out  1  memory address: 0=PC, 1=ALUOut.
REQ-015 SHALL have port mem_rd  out  1  memory read request.
REQ-016 SHALL have port mem_wr  out  1  memory write strobe.
REQ-017 SHALL have port reg_write  out  1  register-file write strobe.
REQ-018 SHALL have port reg_dst  out  1  0=rt, 1=rd.
REQ-019 SHALL have port mem_to_reg  out  1  0=ALUOut, 1=MDR.
REQ-020 SHALL have port epc_write  out  1  EPC load strobe.
REQ-021 SHALL have port cause  out  2  00 none, 01 invalid opcode/funct, 10 overflow; valid when epc_write=1.

Function
REQ-022 SHALL be a Moore FSM: FETCH, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, MEM_ADDR, MEM_READ, LOAD_WB, MEM_WRITE, BRANCH, JUMP, EXC; all outputs decoded from state (plus zero in BRANCH); unlisted strobes 0.
REQ-023 SHALL in FETCH assert mem_rd, iord=0, for MEM_LAT cycles (3-bit wait counter); on final cycle assert ir_write and pc_write with alu_src_a=0, alu_src_b=010, alu_op=add, pc_src=00; then DECODE.
REQ-024 SHALL in DECODE drive alu_src_a=0, alu_src_b=100, alu_op=add (branch target to ALUOut), then dispatch: 0x00->R_EXEC, 0x08->ADDI_EXEC, 0x23/0x2B->MEM_ADDR, 0x04/0x05->BRANCH, 0x02->JUMP, other->EXC (cause 01).
REQ-025 SHALL in R_EXEC drive alu_src_a=1, alu_src_b=000, alu_op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); other funct->EXC (cause 01); else->R_WB (reg_write, reg_dst=1, mem_to_reg=0).
REQ-026 SHALL in ADDI_EXEC drive alu_src_a=1, alu_src_b=001, add, then ADDI_WB (reg_write, reg_dst=0, mem_to_reg=0).
REQ-027 SHALL in MEM_ADDR compute A+ext16_32 (alu_src_b=001); lw->MEM_READ (mem_rd, iord=1, MEM_LAT cycles)->LOAD_WB (reg_write, reg_dst=0, mem_to_reg=1); sw->MEM_WRITE (mem_wr, iord=1, one cycle).
REQ-028 SHALL in BRANCH drive alu_src_a=1, alu_src_b=000, sub, pc_src=01, pc_write=(beq&zero)|(bne&~zero).
REQ-029 SHALL in JUMP assert pc_write with pc_src=10.
REQ-030 SHALL return to FETCH after R_WB, ADDI_WB, LOAD_WB, MEM_WRITE, BRANCH, JUMP, EXC; wait counter cleared on every state entry.
REQ-031 SHALL give latencies (MEM_LAT=1): R/addi 4, lw 5, sw 4, beq/bne/j 3 cycles; each extra MEM_LAT cycle adds 1 to FETCH and MEM_READ.

Reset
REQ-032 SHALL, while reset=1, hold all outputs 0 and load FETCH with counter 0 at the edge, including mid-instruction (no partial write completes).

Configuration
REQ-033 SHALL, with MC_CTRL_EXC_EN defined, enter EXC on invalid opcode/funct or overflow=1 in R_EXEC (add/sub) or ADDI_EXEC (skipping WB); EXC asserts epc_write, cause, pc_write, pc_src=11.
REQ-034 SHALL, without MC_CTRL_EXC_EN, ignore overflow, treat invalid opcode/funct as NOP (->FETCH), tie epc_write=0, cause=00, never drive pc_src=11.

Structure
REQ-035 SHALL place state enum, alu_src_b, alu_op, pc_src, cause, opcode and funct constants in package mc_ctrl_pkg.
REQ-036 SHALL isolate state-to-output decode in one combinational sub-module mc_ctrl_outdec.

Verification
REQ-037 SHALL check add (op 0x00, funct 0x20), MEM_LAT=1 -> alu_src_b 010,100,000 then reg_write=1, reg_dst=1 in cycle 4.
REQ-038 SHALL check lw 0x23, MEM_LAT=3 -> FETCH 3 cycles, MEM_READ 3 cycles, mem_to_reg=1 reg_write=1 in cycle 9.
REQ-039 SHALL check beq zero=1 -> pc_write=1, pc_src=01; bne zero=1 -> pc_write=0.
REQ-040 SHALL check opcode 0x3F with EXC_EN -> epc_write=1, cause=01, pc_src=11; without -> next state FETCH, no strobes.
REQ-041 SHALL check reset=1 during MEM_READ -> outputs 0, FETCH, counter 0 next cycle.
